adder_operand_loader: RTL and testbench

Upstream staging stage for the wide `simple_adder` datapath. Collects two W-bit operands and a carry-in from a narrow BW-bit valid/ready stream, beat by beat. Then holds `a`, `b` and `cin` stable with `op_valid` until the downstream consumer accepts them. The consumer is the adder plus its result register.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_operand_loader.sv | 110 +++++++++++
 tb/tb_adder_operand_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the simple_adder datapath stages (operand loader and result side).
package adder_pkg;

  localparam int ADDER_W  = 256;
  localparam int ADDER_BW = 32;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD_A = ST_LOAD_A,
    S_LOAD_B = ST_LOAD_B,
    S_HOLD   = ST_HOLD
  } loader_state_e;

  // Beat counter width; a single-beat operand still needs a 1-bit counter.
  function automatic int cnt_width(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/adder_operand_loader.sv
// Stages two W-bit operands and a carry-in from a BW-bit valid/ready beat stream
// and holds them with op_valid until the adder accepts them.
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int W  = ADDER_W,
  parameter int BW = ADDER_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in_data,
  input  logic          in_cin,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          cin,
  output logic          op_valid,
  input  logic          op_ready
);

  localparam int NBEATS = W / BW;
  localparam int CW     = cnt_width(NBEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

  if ((W % BW) != 0) begin : g_bad_width
    $error("adder_operand_loader: W must be an integer multiple of BW");
  end

  loader_state_e state_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          cin_r;
  logic          in_ready_s;
  logic          op_valid_s;

  // FSM, beat counter and operand slice writes; in LOAD_* in_ready is 1, so in_valid alone accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_LOAD_A;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD_A: begin
          if (in_valid) begin
            a_r[int'(cnt_r) * BW +: BW] <= in_data;
            if (cnt_r == LAST_CNT) begin
              cnt_r   <= '0;
              state_r <= S_LOAD_B;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            b_r[int'(cnt_r) * BW +: BW] <= in_data;
            if (cnt_r == LAST_CNT) begin
              cin_r   <= in_cin;
              cnt_r   <= '0;
              state_r <= S_HOLD;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (op_ready) begin
            state_r <= S_LOAD_A;
          end
        end
        default: begin
          state_r <= S_LOAD_A;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Handshake flags decode from state only, forced low while reset is held.
  always_comb begin
    in_ready_s = 1'b0;
    op_valid_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
      op_valid_s = 1'b0;
    end else begin
      case (state_r)
        S_LOAD_A: in_ready_s = 1'b1;
        S_LOAD_B: in_ready_s = 1'b1;
        S_HOLD:   op_valid_s = 1'b1;
        default: begin
          in_ready_s = 1'b0;
          op_valid_s = 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign op_valid = op_valid_s;
  assign a        = a_r;
  assign b        = b_r;
  assign cin      = cin_r;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed self-checking bench for adder_operand_loader with W=256, BW=32.
module tb_adder_operand_loader;

  localparam int W  = 256;
  localparam int BW = 32;
  localparam int NB = W / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_cin;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          op_valid;
  logic          op_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  adder_operand_loader #(.W(W), .BW(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_cin   (in_cin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op_valid (op_valid),
    .op_ready (op_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    op_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One beat followed by gap idle cycles carrying junk data with in_valid low.
  task automatic send_beat(input logic [BW-1:0] d, input logic c, input int gap);
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_data = 32'hDEAD_BEEF;
      in_cin  = 1'b1;
      tick();
    end
  endtask

  task automatic load_beats(input logic [W-1:0] v, input int first, input int n,
                            input int gap, input logic cin_all, input logic cin_last);
    for (int i = first; i < first + n; i++) begin
      send_beat(v[i*BW +: BW], (i == NB - 1) ? cin_last : cin_all, gap);
    end
  endtask

  task automatic release_op();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run += 5;
    if (a !== {W{1'b0}}) begin tests_failed++; $display("FAIL reset_a: got %h expected 0", a); end
    if (b !== {W{1'b0}}) begin tests_failed++; $display("FAIL reset_b: got %h expected 0", b); end
    if (cin !== 1'b0) begin tests_failed++; $display("FAIL reset_cin: got %b expected 0", cin); end
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    tests_run += 2;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL release_op_valid: got %b expected 0", op_valid); end
  endtask

  // Shared body for the all-ones + zero operation, with and without bubbles.
  task automatic run_ones_zero(input string tag, input int gap);
    logic [W:0] total;
    load_beats({W{1'b1}}, 0, NB, gap, 1'b0, 1'b0);
    load_beats({W{1'b0}}, 0, NB - 1, gap, 1'b0, 1'b0);
    tests_run++;
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_early_op_valid: got %b expected 0", tag, op_valid); end
    send_beat(32'h0000_0000, 1'b1, 0);
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    tests_run += 6;
    if (op_valid !== 1'b1) begin tests_failed++; $display("FAIL %s_op_valid: got %b expected 1", tag, op_valid); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL %s_in_ready: got %b expected 0", tag, in_ready); end
    if (a !== {W{1'b1}}) begin tests_failed++; $display("FAIL %s_a: got %h expected all ones", tag, a); end
    if (b !== {W{1'b0}}) begin tests_failed++; $display("FAIL %s_b: got %h expected 0", tag, b); end
    if (cin !== 1'b1) begin tests_failed++; $display("FAIL %s_cin: got %b expected 1", tag, cin); end
    if (total !== {1'b1, {W{1'b0}}}) begin tests_failed++; $display("FAIL %s_sum: got %h expected cout=1 sum=0", tag, total); end
  endtask

  task automatic test_back_to_back();
    run_ones_zero("b2b", 0);
    release_op();
    tests_run += 2;
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_release_op_valid: got %b expected 0", op_valid); end
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_bubbles();
    do_reset();
    run_ones_zero("bubble", 3);
    release_op();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic [W-1:0] new_a;
    for (int i = 0; i < NB; i++) begin
      exp_a[i*BW +: BW] = 32'h0000_1000 + 32'(i);
      exp_b[i*BW +: BW] = 32'h0000_2000 + 32'(i);
      new_a[i*BW +: BW] = 32'(i + 1);
    end
    do_reset();
    load_beats(exp_a, 0, NB, 0, 1'b0, 1'b0);
    load_beats(exp_b, 0, NB, 0, 1'b0, 1'b0);
    in_data  = 32'hBAD0_BAD0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests_run += 4;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready c%0d: got %b expected 0", c, in_ready); end
      if (op_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_op_valid c%0d: got %b expected 1", c, op_valid); end
      if (a !== exp_a) begin tests_failed++; $display("FAIL hold_a c%0d: got %h expected %h", c, a, exp_a); end
      if (b !== exp_b) begin tests_failed++; $display("FAIL hold_b c%0d: got %h expected %h", c, b, exp_b); end
      tick();
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    in_valid = 1'b0;
    tests_run += 3;
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL accept_op_valid: got %b expected 0", op_valid); end
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL accept_in_ready: got %b expected 1", in_ready); end
    if (a !== exp_a) begin tests_failed++; $display("FAIL accept_no_overlap_a: got %h expected %h", a, exp_a); end
    load_beats(new_a, 0, NB, 0, 1'b0, 1'b0);
    tests_run += 5;
    if (a[31:0] !== 32'd1) begin tests_failed++; $display("FAIL order_a_low: got %h expected 1", a[31:0]); end
    if (a[255:224] !== 32'd8) begin tests_failed++; $display("FAIL order_a_high: got %h expected 8", a[255:224]); end
    if (a !== new_a) begin tests_failed++; $display("FAIL order_a: got %h expected %h", a, new_a); end
    if (b !== exp_b) begin tests_failed++; $display("FAIL order_b_kept: got %h expected %h", b, exp_b); end
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL order_op_valid: got %b expected 0", op_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    for (int i = 0; i < NB; i++) begin
      exp_a[i*BW +: BW] = 32'h0000_3000 + 32'(i);
      exp_b[i*BW +: BW] = 32'h0000_4000 + 32'(i);
    end
    do_reset();
    load_beats({W{1'b1}}, 0, 5, 0, 1'b0, 1'b0);
    rst      = 1'b1;
    in_data  = 32'h5555_5555;
    in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tests_run += 2;
    if (a !== {W{1'b0}}) begin tests_failed++; $display("FAIL midrst_a_cleared: got %h expected 0", a); end
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_op_valid: got %b expected 0", op_valid); end
    load_beats(exp_a, 0, NB, 0, 1'b0, 1'b0);
    load_beats(exp_b, 0, NB - 1, 0, 1'b0, 1'b0);
    tests_run++;
    if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale_op_valid: got %b expected 0", op_valid); end
    load_beats(exp_b, NB - 1, 1, 0, 1'b0, 1'b0);
    tests_run += 3;
    if (op_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_new_op_valid: got %b expected 1", op_valid); end
    if (a !== exp_a) begin tests_failed++; $display("FAIL midrst_new_a: got %h expected %h", a, exp_a); end
    if (b !== exp_b) begin tests_failed++; $display("FAIL midrst_new_b: got %h expected %h", b, exp_b); end
    release_op();
  endtask

  task automatic test_cin_mask();
    load_beats({W{1'b0}}, 0, NB, 0, 1'b1, 1'b1);
    load_beats({W{1'b0}}, 0, NB, 0, 1'b1, 1'b0);
    tests_run += 2;
    if (op_valid !== 1'b1) begin tests_failed++; $display("FAIL cinmask_op_valid: got %b expected 1", op_valid); end
    if (cin !== 1'b0) begin tests_failed++; $display("FAIL cinmask_cin: got %b expected 0", cin); end
    release_op();
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = 32'h0000_0000;
    in_cin   = 1'b0;
    in_valid = 1'b0;
    op_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_cin_mask();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
